// File: rtl/bitcount_hs_if.sv
// ----------------------------------------------------------------------------
// bitcount_hs_if
// Block-level ap_ctrl_hs handshake bundle for the bit-count core.
//   ap_start      controller -> core  start request
//   num   [W]     controller -> core  operand (sampled on the start cycle)
//   ap_done       core -> controller  one-cycle result pulse
//   ap_idle       core -> controller  core is idle
//   ap_ready      core -> controller  one-cycle pulse, new operand accepted
//   hbits [OUTW]  core -> controller  popcount result, held between runs
//   hbits_ap_vld  core -> controller  one-cycle pulse, hbits valid
// master: the controller side; slave: the core side.
// ----------------------------------------------------------------------------
interface bitcount_hs_if #(
   parameter int W    = 10,
   parameter int OUTW = 4
);
   logic            ap_start;
   logic [W-1:0]    num;
   logic            ap_done;
   logic            ap_idle;
   logic            ap_ready;
   logic [OUTW-1:0] hbits;
   logic            hbits_ap_vld;

   modport master (
      output ap_start, num,
      input  ap_done, ap_idle, ap_ready, hbits, hbits_ap_vld
   );

   modport slave (
      input  ap_start, num,
      output ap_done, ap_idle, ap_ready, hbits, hbits_ap_vld
   );
endinterface

// File: rtl/bitcount_hs_core.sv
// ----------------------------------------------------------------------------
// bitcount_hs_core
// Counts the set bits of a W-bit word, one bit per clock, behind an
// ap_ctrl_hs handshake. Latency from the start-sample edge to ap_done is
// always W+1 cycles; the count saturates at 2^OUTW-1.
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RESET  synchronous, active-high reset (aborts a run silently)
//   bus    bitcount_hs_if.slave handshake bundle (see interface header)
// ----------------------------------------------------------------------------
module bitcount_hs_core #(
   parameter int W    = 10,
   parameter int OUTW = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   bitcount_hs_if.slave  bus
);

   localparam int CNTW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    sr_reg, sr_next;
   logic [OUTW-1:0] acc_reg, acc_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;
   logic [OUTW-1:0] hbits_reg, hbits_next;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= IDLE;
         sr_reg    <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         hbits_reg <= '0;
      end else begin
         state_reg <= state_next;
         sr_reg    <= sr_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         hbits_reg <= hbits_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sr_next    = sr_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      hbits_next = hbits_reg;
      case (state_reg)
         IDLE: begin
            if (bus.ap_start) begin
               sr_next    = bus.num;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = CALC;
            end
         end
         CALC: begin
            // Hold at all-ones rather than wrapping.
            if (acc_reg == {OUTW{1'b1}})
               acc_next = acc_reg;
            else
               acc_next = acc_reg + OUTW'(sr_reg[0]);
            sr_next  = sr_reg >> 1;
            cnt_next = cnt_reg + CNTW'(1);
            if (cnt_reg == CNT_LAST) begin
               // The last bit is being added now, so capture the updated sum.
               hbits_next = acc_next;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.ap_idle      = (state_reg == IDLE);
   assign bus.ap_done      = (state_reg == DONE);
   assign bus.ap_ready     = (state_reg == DONE);
   assign bus.hbits_ap_vld = (state_reg == DONE);
   assign bus.hbits        = hbits_reg;

endmodule

// File: tb/tb_bitcount_hs_core.sv
// ----------------------------------------------------------------------------
// tb_bitcount_hs_core
// Directed and randomized checks of bitcount_hs_core against a popcount
// reference model. Two instances: default widths, and OUTW=3 for saturation.
// ----------------------------------------------------------------------------
module tb_bitcount_hs_core;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   bitcount_hs_if #(.W(10), .OUTW(4)) if1 ();
   bitcount_hs_if #(.W(10), .OUTW(3)) if2 ();

   bitcount_hs_core #(.W(10), .OUTW(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if1.slave)
   );

   bitcount_hs_core #(.W(10), .OUTW(3)) dut_sat (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if2.slave)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Popcount, clipped to the largest value an outw-bit result can hold.
   function automatic int ref_pop(input logic [9:0] v, input int outw);
      int c;
      int mx;
      c  = $countones(v);
      mx = (1 << outw) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One run on the default instance: start held until ap_done. num is
   // switched to alt after the start edge to show it is not re-sampled.
   task automatic run1(input logic [9:0] v, input logic [9:0] alt, input string tag);
      int   cyc;
      logic got;
      logic idle_seen;
      cyc       = 0;
      got       = 1'b0;
      idle_seen = 1'b0;
      if1.num      = v;
      if1.ap_start = 1'b1;
      while (!got && cyc < 30) begin
         tick();
         cyc++;
         if (cyc == 1) if1.num = alt;
         if (if1.ap_done) got = 1'b1;
         else idle_seen = idle_seen | if1.ap_idle;
      end
      if1.ap_start = 1'b0;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, cyc, 32'd11);
      chk({tag, "_idle_in_calc"}, 32'(idle_seen), 32'd0);
      chk({tag, "_hbits"}, 32'(if1.hbits), ref_pop(v, 4));
      chk({tag, "_ready"}, 32'(if1.ap_ready), 32'd1);
      chk({tag, "_vld"}, 32'(if1.hbits_ap_vld), 32'd1);
      tick();
      chk({tag, "_idle_after"}, 32'(if1.ap_idle), 32'd1);
      chk({tag, "_done_low_after"}, 32'(if1.ap_done), 32'd0);
      $display("run %s num=%03h hbits=%0d latency=%0d", tag, v, if1.hbits, cyc);
   endtask

   initial begin
      int   t;
      int   last_t;
      int   dones;
      int   idle_between;
      int   cyc;
      logic got;
      logic [9:0] rv;

      // Reset
      RESET        = 1'b1;
      if1.ap_start = 1'b0;
      if1.num      = '0;
      if2.ap_start = 1'b0;
      if2.num      = '0;
      tick();
      tick();
      chk("rst_idle", 32'(if1.ap_idle), 32'd1);
      chk("rst_done", 32'(if1.ap_done), 32'd0);
      chk("rst_ready", 32'(if1.ap_ready), 32'd0);
      chk("rst_vld", 32'(if1.hbits_ap_vld), 32'd0);
      chk("rst_hbits", 32'(if1.hbits), 32'd0);
      chk("rst_sat_hbits", 32'(if2.hbits), 32'd0);
      RESET = 1'b0;
      tick();
      $display("reset idle=%0d hbits=%0d", if1.ap_idle, if1.hbits);

      // Directed single runs
      run1(10'h3FF, 10'h3FF, "all_ones");
      run1(10'h000, 10'h000, "zero");
      run1(10'h155, 10'h155, "alt_bits");

      // Operand latched on the start edge only
      run1(10'h001, 10'h3FF, "latched");
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("latched_hold", 32'(if1.hbits), 32'd1);
      end

      // Randomized runs
      for (int i = 0; i < 6; i++) begin
         rv = 10'($urandom_range(0, 1023));
         run1(rv, 10'($urandom_range(0, 1023)), "random");
      end

      // Continuous start: back-to-back runs, one idle cycle between them
      if1.num      = 10'h0F0;
      if1.ap_start = 1'b1;
      t            = 0;
      last_t       = -1;
      dones        = 0;
      idle_between = 0;
      while (dones < 3 && t < 60) begin
         tick();
         t++;
         chk("cont_ready_eq_done", 32'(if1.ap_ready), 32'(if1.ap_done));
         chk("cont_vld_eq_done", 32'(if1.hbits_ap_vld), 32'(if1.ap_done));
         if (if1.ap_done) begin
            dones++;
            chk("cont_hbits", 32'(if1.hbits), ref_pop(10'h0F0, 4));
            if (last_t >= 0) begin
               chk("cont_period", t - last_t, 32'd12);
               chk("cont_idle_cycles", idle_between, 32'd1);
            end
            $display("cont done #%0d at cycle %0d hbits=%0d", dones, t, if1.hbits);
            last_t       = t;
            idle_between = 0;
         end else if (if1.ap_idle) begin
            idle_between++;
         end
      end
      chk("cont_done_count", dones, 32'd3);
      if1.ap_start = 1'b0;
      tick();

      // Reset in the middle of a run
      if1.num      = 10'h3FF;
      if1.ap_start = 1'b1;
      tick();
      if1.ap_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("midrst_idle", 32'(if1.ap_idle), 32'd1);
      chk("midrst_hbits", 32'(if1.hbits), 32'd0);
      chk("midrst_done", 32'(if1.ap_done), 32'd0);
      got = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         got = got | if1.ap_done;
      end
      chk("midrst_no_done", 32'(got), 32'd0);
      $display("reset mid-run idle=%0d hbits=%0d", if1.ap_idle, if1.hbits);
      run1(10'h007, 10'h007, "after_rst");

      // Saturation on the OUTW=3 instance
      if2.num      = 10'h3FF;
      if2.ap_start = 1'b1;
      cyc          = 0;
      got          = 1'b0;
      while (!got && cyc < 30) begin
         tick();
         cyc++;
         if (if2.ap_done) got = 1'b1;
      end
      if2.ap_start = 1'b0;
      chk("sat_done_seen", 32'(got), 32'd1);
      chk("sat_latency", cyc, 32'd11);
      chk("sat_hbits", 32'(if2.hbits), ref_pop(10'h3FF, 3));
      $display("saturation num=3ff hbits=%0d latency=%0d", if2.hbits, cyc);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bitcount_hs_core.md
# bitcount_hs_core

Hand-written RTL responder for the ap_ctrl_hs block-level handshake. It counts the set bits of an input word, one bit per clock. It is a drop-in, port-compatible replacement for the HLS-generated bit-count core, so the existing board-level controller (ap_start held until ap_done, result captured on ap_done) drives it unchanged. It also serves as the reference model when verifying the generated core.

## Interface
Parameters:
- W, 10, width of the input word num.
- OUTW, 4, width of the result hbits; the count saturates at 2^OUTW-1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ap_start  in  1  start request from the controller.
- num  in  W  operand; sampled only on the start cycle.
- ap_done  out  1  one-cycle pulse; the result is valid on hbits.
- ap_idle  out  1  high while the core is in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done; a new operand may be applied.
- hbits  out  OUTW  popcount result; holds its value between runs.
- hbits_ap_vld  out  1  one-cycle pulse, coincident with ap_done.

## Operation
- **FSM states:** IDLE, CALC, DONE. All outputs are decoded from registered state or held in registers; none is combinational from the inputs.
- **IDLE:**
  - ap_idle=1.
  - If ap_start=1 at the clock edge: latch num into shift register sr, clear acc and bit counter cnt, go to CALC.
  - Otherwise remain in IDLE.
- **CALC:**
  - Each cycle: acc <= acc + sr[0], saturating at 2^OUTW-1; sr <= sr >> 1; cnt <= cnt + 1.
  - When cnt = W-1 (the last bit is being processed), go to DONE.
  - ap_start and num are ignored throughout CALC.
- **DONE:**
  - Register acc into hbits on entry; hbits is updated only at this point.
  - In the DONE cycle, ap_done = ap_ready = hbits_ap_vld = 1.
  - Next state is always IDLE, even if ap_start is still high.
- **Restart:** a new run starts only from IDLE. With ap_start held high continuously, runs repeat back-to-back with exactly one IDLE cycle between them.
- **Width rules:**
  - cnt is clog2(W) bits wide.
  - acc is OUTW bits wide and never wraps.
  - With the default parameters, W=10 fits in OUTW=4, so saturation is unreachable.
- **Reset (any state, including mid-CALC):**
  - Next state is IDLE; sr, acc, cnt and hbits are cleared to 0.
  - No done, ready or vld pulse is generated for the aborted run.
- **Reset values:** ap_idle=1 (state IDLE); ap_done=0; ap_ready=0; hbits_ap_vld=0; hbits=0.

## Timing
- Cycle 0: IDLE, ap_start=1 sampled at the edge ending cycle 0.
- Cycles 1..W: CALC, with ap_idle=0.
- Cycle W+1: DONE. hbits is valid, and ap_done, ap_ready and hbits_ap_vld are high.
- Cycle W+2: IDLE, ap_idle=1.
- Fixed latency from start-sample edge to ap_done is W+1 cycles (11 for the defaults). There is no data-dependent early exit.
- hbits is stable from cycle W+1 until the next DONE or reset.
- Controller compatibility: a controller that drops ap_start on the edge ending the ap_done cycle causes no re-trigger.
- ap_start=1 asserted while the core is busy is neither queued nor lost. It is honoured at the next IDLE cycle if still high.
- RESET has priority over ap_start in the same cycle.

## Test plan
- **Reset values:** apply RESET for 2 cycles -> ap_idle=1, ap_done=0, ap_ready=0, hbits_ap_vld=0, hbits=0.
- **Single runs:** for each operand, pulse ap_start until ap_done -> required result, with ap_done in cycle 11 after the sample edge and ap_idle=1 in cycle 12:
  - num=10'h3FF -> hbits=4'hA.
  - num=10'h000 -> hbits=0.
  - num=10'h155 -> hbits=5.
- **Operand latched:** start with num=10'h001, change num to 10'h3FF during CALC -> hbits=1; hbits holds 1 for 20 idle cycles afterwards.
- **Continuous start:** hold ap_start=1 with num=10'h0F0 -> ap_done pulses every 12 cycles, hbits=4 each time, one ap_idle=1 cycle between runs, and ap_ready=hbits_ap_vld=ap_done each time.
- **Reset mid-run:** start with num=10'h3FF, assert RESET in cycle 5 -> no ap_done pulse, hbits=0, ap_idle=1 the next cycle; a subsequent start with num=10'h007 -> hbits=3.
- **Saturation:** set W=10, OUTW=3, num=10'h3FF -> hbits=7, with no wrap to 2.
